// File: rtl/alu_op_pkg.sv
// Shared constants and types for the ALU operation sequencer.
package alu_op_pkg;

  // ALU operation codes
  localparam logic [3:0] AluAnd    = 4'b0000;
  localparam logic [3:0] AluOr     = 4'b0001;
  localparam logic [3:0] AluSum    = 4'b0010;
  localparam logic [3:0] AluEqual  = 4'b0011;
  localparam logic [3:0] AluSll    = 4'b0100;
  localparam logic [3:0] AluSrl    = 4'b0101;
  localparam logic [3:0] AluSra    = 4'b0111;
  localparam logic [3:0] AluXor    = 4'b1000;
  localparam logic [3:0] AluMuldiv = 4'b1001;
  localparam logic [3:0] AluSub    = 4'b1010;
  localparam logic [3:0] AluBlt    = 4'b1100;
  localparam logic [3:0] AluBltu   = 4'b1101;
  localparam logic [3:0] AluSlt    = 4'b1110;
  localparam logic [3:0] AluSltu   = 4'b1111;

  // ALU_CO instruction classes
  localparam logic [1:0] CoMem    = 2'b00;
  localparam logic [1:0] CoBranch = 2'b01;
  localparam logic [1:0] CoAlu    = 2'b10;
  localparam logic [1:0] CoRsvd   = 2'b11;

  // FUNC7 encodings
  localparam logic [6:0] Func7Base   = 7'b0000000;
  localparam logic [6:0] Func7Alt    = 7'b0100000;
  localparam logic [6:0] Func7Muldiv = 7'b0000001;

  typedef enum logic [0:0] {StIdle, StBusy} seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Decoder-side request and execute-side result signals of the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned OP_W = 4
) ();
  logic            valid_i;
  logic            ready_o;
  logic            is_immediate_i;
  logic [1:0]      ALU_CO_i;
  logic [6:0]      FUNC7_i;
  logic [2:0]      FUNC3_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OP_W-1:0] ALU_OP_o;
  logic            illegal_o;
  logic            md_start_o;
  logic [2:0]      md_op_o;

  // Sequencer side
  modport slave (
    input  valid_i, is_immediate_i, ALU_CO_i, FUNC7_i, FUNC3_i, out_ready_i,
    output ready_o, out_valid_o, ALU_OP_o, illegal_o, md_start_o, md_op_o
  );

  // Decoder / execute side
  modport master (
    output valid_i, is_immediate_i, ALU_CO_i, FUNC7_i, FUNC3_i, out_ready_i,
    input  ready_o, out_valid_o, ALU_OP_o, illegal_o, md_start_o, md_op_o
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of an instruction slice into an ALU code, illegal flag and M-op flag.
module alu_op_decode
  import alu_op_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic       is_immediate_i,
  input  logic [1:0] alu_co_i,
  input  logic [6:0] func7_i,
  input  logic [2:0] func3_i,
  output logic [3:0] op_o,
  output logic       illegal_o,
  output logic       is_md_o
);

  // Class / funct decode; illegal encodings force the code to zero at the end
  always_comb begin
    op_o      = AluAnd;
    illegal_o = 1'b0;
    is_md_o   = 1'b0;
    unique case (alu_co_i)
      CoMem: op_o = AluSum;
      CoBranch: begin
        unique case (func3_i)
          3'b000, 3'b010, 3'b011: op_o = AluSub;
          3'b001:                 op_o = AluEqual;
          3'b100:                 op_o = AluBlt;
          3'b101:                 op_o = AluSlt;
          3'b110:                 op_o = AluBltu;
          3'b111:                 op_o = AluSltu;
        endcase
      end
      CoAlu: begin
        if (!is_immediate_i && (func7_i == Func7Muldiv)) begin
          if (ENABLE_M) begin
            op_o    = AluMuldiv;
            is_md_o = 1'b1;
          end else begin
            illegal_o = 1'b1;
          end
        end else begin
          unique case (func3_i)
            3'b000: begin
              // Immediate form carries imm bits in FUNC7, so it is always an add
              if (is_immediate_i || (func7_i == Func7Base)) op_o = AluSum;
              else if (func7_i == Func7Alt)                 op_o = AluSub;
              else                                          illegal_o = 1'b1;
            end
            3'b001: begin
              if (func7_i == Func7Base) op_o = AluSll;
              else                      illegal_o = 1'b1;
            end
            3'b101: begin
              if (func7_i == Func7Base)     op_o = AluSrl;
              else if (func7_i == Func7Alt) op_o = AluSra;
              else                          illegal_o = 1'b1;
            end
            default: begin
              unique case (func3_i)
                3'b010:  op_o = AluSlt;
                3'b011:  op_o = AluSltu;
                3'b100:  op_o = AluXor;
                3'b110:  op_o = AluOr;
                default: op_o = AluAnd;
              endcase
              if (!is_immediate_i && (func7_i != Func7Base)) illegal_o = 1'b1;
            end
          endcase
        end
      end
      CoRsvd: illegal_o = 1'b1;
    endcase
    if (illegal_o) op_o = AluAnd;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU op sequencer with a stall path for multi-cycle M ops.
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave seq_io
);

  localparam int unsigned MaxLat = max_u(MUL_LAT, DIV_LAT);
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            md_start_q, md_start_d;
  logic [2:0]      md_op_q, md_op_d;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      op_q, op_d;
  logic            illegal_q, illegal_d;

  logic       dec_is_md, dec_ill;
  logic [3:0] dec_op;
  logic       ready, accept;
  logic       load, load_ill;
  logic [3:0] load_op;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .is_immediate_i (seq_io.is_immediate_i),
    .alu_co_i       (seq_io.ALU_CO_i),
    .func7_i        (seq_io.FUNC7_i),
    .func3_i        (seq_io.FUNC3_i),
    .op_o           (dec_op),
    .illegal_o      (dec_ill),
    .is_md_o        (dec_is_md)
  );

  assign ready  = (state_q == StIdle) && (!out_valid_q || seq_io.out_ready_i);
  assign accept = seq_io.valid_i && ready;

  // FSM next state, latency counter and result-load request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    load       = 1'b0;
    load_op    = AluAnd;
    load_ill   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (dec_is_md) begin
            // FUNC3[2] separates DIV/REM from MUL variants
            cnt_d      = seq_io.FUNC3_i[2] ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
            md_op_d    = seq_io.FUNC3_i;
            md_start_d = 1'b1;
            state_d    = StBusy;
          end else begin
            load     = 1'b1;
            load_op  = dec_op;
            load_ill = dec_ill;
          end
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(1)) begin
          load    = 1'b1;
          load_op = AluMuldiv;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
  end

  // Output register: a new result wins over a consume on the same edge
  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    if (load) begin
      out_valid_d = 1'b1;
      op_d        = load_op;
      illegal_d   = load_ill;
    end else if (seq_io.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      md_start_q  <= 1'b0;
      md_op_q     <= 3'b000;
      out_valid_q <= 1'b0;
      op_q        <= AluAnd;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
    end
  end

  assign seq_io.ready_o     = ready;
  assign seq_io.out_valid_o = out_valid_q;
  assign seq_io.ALU_OP_o    = OP_W'(op_q);
  assign seq_io.illegal_o   = illegal_q;
  assign seq_io.md_start_o  = md_start_q;
  assign seq_io.md_op_o     = md_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus a randomized scoreboard run.
module tb_alu_op_sequencer;

  localparam int unsigned MulLat = 3;
  localparam int unsigned DivLat = 32;

  localparam logic [3:0] OpAnd = 4'b0000, OpOr = 4'b0001, OpSum = 4'b0010, OpEq = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100, OpSrl = 4'b0101, OpSra = 4'b0111, OpXor = 4'b1000;
  localparam logic [3:0] OpMd = 4'b1001, OpSub = 4'b1010, OpSlt = 4'b1110, OpSltu = 4'b1111;

  // Branch and ALU results indexed by FUNC3
  localparam logic [3:0] BranchTbl [8] = '{OpSub, OpEq, OpSub, OpSub, 4'b1100, OpSlt, 4'b1101,
                                           OpSltu};
  localparam logic [3:0] AluTbl [8] = '{OpSum, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpOr, OpAnd};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.OP_W(4)) bus ();
  alu_op_sequencer_if #(.OP_W(4)) bus_nm ();

  alu_op_sequencer #(
    .OP_W(4), .MUL_LAT(MulLat), .DIV_LAT(DivLat), .ENABLE_M(1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_io (bus)
  );

  alu_op_sequencer #(
    .OP_W(4), .MUL_LAT(2), .DIV_LAT(4), .ENABLE_M(1'b0)
  ) dut_nm (
    .clk    (clk),
    .rst    (rst),
    .seq_io (bus_nm)
  );

  typedef struct {
    logic [3:0] op;
    logic       ill;
    int         vis;
  } exp_t;

  // Reference decode from the ISA-level rules
  function automatic void ref_decode(input logic imm, input logic [1:0] co, input logic [6:0] f7,
                                     input logic [2:0] f3, input bit enm, output logic [3:0] op,
                                     output logic ill, output logic md);
    bit shift;
    op = OpAnd; ill = 1'b0; md = 1'b0;
    if (co == 2'd0) op = OpSum;
    else if (co == 2'd1) op = BranchTbl[f3];
    else if (co == 2'd3) ill = 1'b1;
    else if (!imm && f7 == 7'd1) begin
      if (enm) begin op = OpMd; md = 1'b1; end
      else ill = 1'b1;
    end else begin
      op = AluTbl[f3];
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      if (shift || !imm) begin
        if (f7 == 7'd0) ;
        else if (f7 == 7'h20 && f3 == 3'd0 && !imm) op = OpSub;
        else if (f7 == 7'h20 && f3 == 3'd5) op = OpSra;
        else ill = 1'b1;
      end
    end
    if (ill) op = OpAnd;
  endfunction

  task automatic drive(input logic v, input logic imm, input logic [1:0] co, input logic [6:0] f7,
                       input logic [2:0] f3);
    bus.valid_i = v; bus.is_immediate_i = imm; bus.ALU_CO_i = co;
    bus.FUNC7_i = f7; bus.FUNC3_i = f3;
  endtask

  task automatic idle_cycles(input int n);
    bus.valid_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 7'd0, 3'b000);
    bus.out_ready_i = 1'b1;
    bus_nm.valid_i = 1'b0; bus_nm.out_ready_i = 1'b1; bus_nm.is_immediate_i = 1'b0;
    bus_nm.ALU_CO_i = 2'b00; bus_nm.FUNC7_i = 7'd0; bus_nm.FUNC3_i = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid_o); end
    tests++; if (bus.ALU_OP_o !== 4'd0) begin fails++; $display("FAIL reset_alu_op: got %b expected 0000", bus.ALU_OP_o); end
    tests++; if (bus.illegal_o !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal_o); end
    tests++; if (bus.md_start_o !== 1'b0) begin fails++; $display("FAIL reset_md_start: got %b expected 0", bus.md_start_o); end
    tests++; if (bus.md_op_o !== 3'd0) begin fails++; $display("FAIL reset_md_op: got %b expected 000", bus.md_op_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", bus.ready_o); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.ALU_OP_o !== OpSum) begin fails++; $display("FAIL first_accept_sum: got v=%b op=%b expected v=1 op=0010", bus.out_valid_o, bus.ALU_OP_o); end
    @(posedge clk); #1;
    idle_cycles(2);
  endtask

  task automatic test_stream;
    logic [1:0] co [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [6:0] f7 [5] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00};
    logic [2:0] f3 [5] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010};
    logic [3:0] ex [5] = '{OpSum, OpSub, OpSra, OpEq, OpSum};
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, 1'b0, co[i], f7[i], f3[i]);
      else bus.valid_i = 1'b0;
      @(negedge clk);
      tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.ready_o); end
      if (i > 0) begin
        tests++;
        if (bus.out_valid_o !== 1'b1 || bus.ALU_OP_o !== ex[i-1] || bus.illegal_o !== 1'b0) begin
          fails++;
          $display("FAIL stream_op[%0d]: got v=%b op=%b ill=%b expected v=1 op=%b ill=0", i - 1, bus.out_valid_o, bus.ALU_OP_o, bus.illegal_o, ex[i-1]);
        end
      end
      @(posedge clk); #1;
    end
    idle_cycles(1);
  endtask

  task automatic test_mul;
    drive(1'b1, 1'b0, 2'b10, 7'd1, 3'b000);
    @(negedge clk);
    tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL mul_accept_ready: got %b expected 1", bus.ready_o); end
    @(posedge clk); #1 bus.valid_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++;
      if (bus.ready_o !== 1'b0 || bus.md_start_o !== (k == 1) || bus.md_op_o !== 3'b000 || bus.out_valid_o !== 1'b0) begin
        fails++;
        $display("FAIL mul_busy[%0d]: got rdy=%b start=%b mdop=%b v=%b expected rdy=0 start=%b mdop=000 v=0", k, bus.ready_o, bus.md_start_o, bus.md_op_o, bus.out_valid_o, (k == 1));
      end
      @(posedge clk);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid_o !== 1'b1 || bus.ALU_OP_o !== OpMd || bus.md_start_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL mul_result: got v=%b op=%b start=%b rdy=%b expected v=1 op=1001 start=0 rdy=1", bus.out_valid_o, bus.ALU_OP_o, bus.md_start_o, bus.ready_o);
    end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_div_reset;
    logic saw;
    drive(1'b1, 1'b0, 2'b10, 7'd1, 3'b100);
    @(posedge clk); #1 bus.valid_i = 1'b0;
    @(negedge clk);
    tests++; if (bus.md_start_o !== 1'b1 || bus.md_op_o !== 3'b100 || bus.ready_o !== 1'b0) begin fails++; $display("FAIL div_start: got start=%b mdop=%b rdy=%b expected 1 100 0", bus.md_start_o, bus.md_op_o, bus.ready_o); end
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      saw = saw | bus.out_valid_o | bus.md_start_o;
    end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL div_reset_discard: got saw_valid_or_start=%b expected 0", saw); end
    tests++; if (bus.ready_o !== 1'b1 || bus.md_op_o !== 3'b000) begin fails++; $display("FAIL div_reset_idle: got rdy=%b mdop=%b expected 1 000", bus.ready_o, bus.md_op_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    logic [1:0] co [2] = '{2'b10, 2'b11};
    logic [6:0] f7 [2] = '{7'h7f, 7'h00};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, co[i], f7[i], 3'b000);
      @(posedge clk); #1 bus.valid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.out_valid_o !== 1'b1 || bus.ALU_OP_o !== 4'd0 || bus.illegal_o !== 1'b1 || bus.ready_o !== 1'b1) begin
        fails++;
        $display("FAIL illegal[%0d]: got v=%b op=%b ill=%b rdy=%b expected 1 0000 1 1", i, bus.out_valid_o, bus.ALU_OP_o, bus.illegal_o, bus.ready_o);
      end
      @(posedge clk); #1;
    end
    bus_nm.valid_i = 1'b1; bus_nm.ALU_CO_i = 2'b10; bus_nm.FUNC7_i = 7'd1;
    bus_nm.FUNC3_i = 3'b000; bus_nm.is_immediate_i = 1'b0;
    @(posedge clk); #1 bus_nm.valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_nm.out_valid_o !== 1'b1 || bus_nm.ALU_OP_o !== 4'd0 || bus_nm.illegal_o !== 1'b1 || bus_nm.md_start_o !== 1'b0 || bus_nm.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL illegal_m_disabled: got v=%b op=%b ill=%b start=%b rdy=%b expected 1 0000 1 0 1", bus_nm.out_valid_o, bus_nm.ALU_OP_o, bus_nm.illegal_o, bus_nm.md_start_o, bus_nm.ready_o);
    end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_backpressure;
    bus.out_ready_i = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 7'd0, 3'b000);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b10, 7'd0, 3'b100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (bus.ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.ALU_OP_o !== OpSum) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b op=%b expected 0 1 0010", k, bus.ready_o, bus.out_valid_o, bus.ALU_OP_o);
      end
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    tests++; if (bus.ready_o !== 1'b1 || bus.ALU_OP_o !== OpSum) begin fails++; $display("FAIL bp_release: got rdy=%b op=%b expected 1 0010", bus.ready_o, bus.ALU_OP_o); end
    @(posedge clk); #1 bus.valid_i = 1'b0;
    @(negedge clk);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.ALU_OP_o !== OpXor) begin fails++; $display("FAIL bp_xor: got v=%b op=%b expected 1 1000", bus.out_valid_o, bus.ALU_OP_o); end
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_random;
    exp_t       q[$];
    int         cur = 0;
    int         md_cyc = -1;
    logic [2:0] md_f3 = 3'd0;
    logic       v, imm, orr, ev, busy, er, ill, md;
    logic [1:0] co;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] op;
    int         r;
    for (int n = 0; n < 700; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      imm = $urandom_range(0, 1) != 0;
      co  = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      r   = $urandom_range(0, 15);
      f7  = (r < 7) ? 7'h00 : (r < 11) ? 7'h20 : (r == 11) ? 7'h01 : 7'($urandom_range(0, 127));
      orr = ($urandom_range(0, 3) != 0);
      drive(v, imm, co, f7, f3);
      bus.out_ready_i = orr;
      @(negedge clk);
      busy = (q.size() > 0) && (q[0].vis > cur);
      ev   = (q.size() > 0) && (q[0].vis <= cur);
      er   = !busy && (!ev || orr);
      tests++; if (bus.out_valid_o !== ev) begin fails++; $display("FAIL rnd_valid@%0d: got %b expected %b", cur, bus.out_valid_o, ev); end
      tests++; if (bus.ready_o !== er) begin fails++; $display("FAIL rnd_ready@%0d: got %b expected %b", cur, bus.ready_o, er); end
      tests++; if (bus.md_start_o !== (cur == md_cyc)) begin fails++; $display("FAIL rnd_md_start@%0d: got %b expected %b", cur, bus.md_start_o, (cur == md_cyc)); end
      if (ev) begin
        tests++;
        if (bus.ALU_OP_o !== q[0].op || bus.illegal_o !== q[0].ill) begin
          fails++;
          $display("FAIL rnd_result@%0d: got op=%b ill=%b expected op=%b ill=%b", cur, bus.ALU_OP_o, bus.illegal_o, q[0].op, q[0].ill);
        end
      end
      if (busy) begin
        tests++; if (bus.md_op_o !== md_f3) begin fails++; $display("FAIL rnd_md_op@%0d: got %b expected %b", cur, bus.md_op_o, md_f3); end
      end
      if (ev && orr) void'(q.pop_front());
      if (v && er) begin
        ref_decode(imm, co, f7, f3, 1'b1, op, ill, md);
        if (md) begin
          q.push_back('{op: OpMd, ill: 1'b0, vis: cur + 1 + int'(f3[2] ? DivLat : MulLat)});
          md_cyc = cur + 1;
          md_f3  = f3;
        end else begin
          q.push_back('{op: op, ill: ill, vis: cur + 1});
        end
      end
      @(posedge clk);
      cur++;
      #1;
    end
    idle_cycles(40);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_mul();
    test_div_reset();
    test_illegal();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered, handshaked successor to the combinational ALU control decoder. It accepts one decoded instruction slice per transaction: ALU class, FUNC3, FUNC7 and the immediate flag. It produces a registered 4-bit ALU operation code with valid/ready flow control. RV32M multiply/divide requests go to an external multi-cycle unit, and the sequencer stalls for a parametrised latency. It sits between the instruction decoder and the execute stage of the core.

## Interface
- OP_W, 4, width of ALU_OP_o; must be ≥4, upper bits zero-filled
- MUL_LAT, 3, cycles from md_start_o to MUL result, ≥1
- DIV_LAT, 32, cycles from md_start_o to DIV/REM result, ≥1
- ENABLE_M, 1, 1 = decode RV32M; 0 = treat M encodings as illegal
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  input transaction present
- ready_o  out  1  sequencer can accept
- is_immediate_i  in  1  I-type ALU instruction
- ALU_CO_i  in  2  00 load/store, 01 branch, 10 ALU, 11 reserved
- FUNC7_i  in  7  funct7
- FUNC3_i  in  3  funct3
- out_valid_o  out  1  ALU_OP_o/illegal_o valid
- out_ready_i  in  1  execute stage consumes result
- ALU_OP_o  out  OP_W  registered operation code
- illegal_o  out  1  encoding not supported; qualifies out_valid_o
- md_start_o  out  1  one-cycle start pulse to multiply/divide unit
- md_op_o  out  3  FUNC3 of the M instruction; held while busy

## Operation
- Codes (package): AND 0000, OR 0001, SUM 0010, EQUAL 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1000, MULDIV 1001, SUB 1010, 1100, 1101, SLT 1110, SLTU 1111.
- ALU_CO 00: SUM.
- ALU_CO 01 by FUNC3:
  - 000/010/011 → SUB
  - 001 → EQUAL
  - 100 → 1100
  - 101 → SLT
  - 110 → 1101
  - 111 → SLTU
- ALU_CO 10 by FUNC3:
  - 000 → SUM if is_immediate_i or FUNC7=0000000; SUB if FUNC7=0100000.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU, 001 SLL.
  - 101 → SRL if FUNC7=0000000; SRA if FUNC7=0100000.
- ALU_CO 10, is_immediate_i=0, FUNC7=0000001, ENABLE_M=1: M op → multi-cycle path, result code MULDIV.
- Illegal cases: any other FUNC7 on an R-type or shift, ALU_CO 11, or M op with ENABLE_M=0. Result is ALU_OP_o=0000 with illegal_o=1. Illegal ops take the single-cycle path.
- FSM states:
  - IDLE: on accept (valid_i & ready_o), a single-cycle op loads the output register and stays in IDLE. An M op loads the counter with MUL_LAT (FUNC3 0xx) or DIV_LAT (FUNC3 1xx), latches md_op_o and goes to BUSY.
  - BUSY: md_start_o=1 in the first BUSY cycle only. The counter decrements each cycle. At count 1, load MULDIV into the output register and go to IDLE.
- Output register: holds ALU_OP_o/illegal_o/out_valid_o stable until out_ready_i. out_valid_o clears on consume unless a new result loads the same edge.
- ready_o = (state==IDLE) & (!out_valid_o | out_ready_i), combinational.

## Timing
- Reset (any state): state IDLE, counter 0, out_valid_o 0, ALU_OP_o 0, illegal_o 0, md_start_o 0, md_op_o 0.
- Reset during BUSY: the pending M op is discarded with no out_valid_o. The external unit is reset by the same rst.
- Single-cycle op accepted at edge N: out_valid_o=1 from N+1. With out_ready_i held 1, one accept per cycle.
- M op accepted at edge N: md_start_o high in cycle N..N+1 and low at every other time. out_valid_o rises at edge N+LAT. ready_o=0 throughout BUSY.
- Simultaneous consume and accept in IDLE: new result replaces old, and out_valid_o stays 1.
- Back-to-back M ops: the second is accepted only once IDLE with the output free, so there is no overlap on md_start_o.
- inputs are sampled only on accept; changes while ready_o=0 are ignored.

## Structure
- Package alu_op_pkg: ALU_OP code localparams, ALU_CO class constants, FUNC7 constants (BASE 0000000, ALT 0100000, MULDIV 0000001), FSM state typedef.
- Sub-module alu_op_decode: purely combinational. Maps (is_immediate, ALU_CO, FUNC7, FUNC3) to {op, illegal, is_md} under ENABLE_M.
- Top alu_op_sequencer holds the FSM, latency counter (width $clog2(max(MUL_LAT,DIV_LAT)+1)) and output register.

## Test plan
- Reset with valid_i=1, ALU_CO=10, FUNC3=000 held → all outputs 0 while rst=1. First accept on the cycle after release gives SUM.
- Stream with out_ready_i=1: ADD, SUB (FUNC7 0100000), SRA (101/0100000), BNE (01/001), LW (00) → 0010, 1010, 0111, 0011, 0010 on consecutive cycles. ready_o stays 1.
- MUL (FUNC7 0000001, FUNC3 000), MUL_LAT=3:
  - md_start_o single pulse, md_op_o=000, ready_o=0 for 3 cycles.
  - ALU_OP_o=1001 three edges after accept.
- DIV (FUNC3 100), DIV_LAT=32, with rst asserted at BUSY cycle 10 → no out_valid_o; IDLE with ready_o=1 after reset.
- Illegal cases → ALU_OP_o=0000, illegal_o=1, single cycle:
  - FUNC7=1111111 R-type ADD
  - ALU_CO=11
  - M op with ENABLE_M=0
- Backpressure with out_ready_i=0 after an ADD → ALU_OP_o held 0010, ready_o=0. A second valid XOR is not accepted until out_ready_i=1. Then the XOR result 1000 appears the next cycle.
